line_fill_memory: RTL



---
 rtl/mem_if_pkg.sv | 17 +
 rtl/line_fill_memory_if.sv | 30 +++
 rtl/mem_array.sv | 27 ++
 rtl/line_fill_memory.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Definitions shared between the line-fill memory responder and the cache side:
// line geometry, default bus widths and the responder's FSM state encoding.
package mem_if_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 16;
   localparam int LINE_WORDS = 4;
   localparam int LINE_OFF_W = 2;

   typedef logic [1:0] fsm_state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_WACK = 2'd3;

endpackage

// File: rtl/line_fill_memory_if.sv
// Request/response bundle between a cache line-fill port (master) and the memory responder (slave).
interface line_fill_memory_if
   import mem_if_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) ();

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic [ADDR_W-1:0] resp_addr;
   logic              resp_last;
   logic              wr_ack;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_data, resp_addr, resp_last, wr_ack
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_data, resp_addr, resp_last, wr_ack
   );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read data; read data holds
// between read enables and is not affected by writes.
module mem_array #(
   parameter int DATA_W         = 16,
   parameter int MEM_DEPTH_LOG2 = 10
) (
   input  logic                      clk,
   input  logic                      en,
   input  logic                      we,
   input  logic [MEM_DEPTH_LOG2-1:0] addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         rdata
);

   logic [DATA_W-1:0] mem [0:(1<<MEM_DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/line_fill_memory.sv
// Main-memory responder: single-word writes and 4-word line reads returned
// one word at a time, each preceded by WAIT_CYCLES idle cycles.
module line_fill_memory
   import mem_if_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int WAIT_CYCLES    = 3
) (
   input  logic             clk_100,
   input  logic             rst_n,
   line_fill_memory_if.slave bus
);

   localparam bit NO_WAIT = (WAIT_CYCLES == 0);
   localparam int CNT_W   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [LINE_OFF_W-1:0] LAST_OFF = LINE_OFF_W'(LINE_WORDS - 1);
   localparam logic [LINE_OFF_W-1:0] OFF_ONE  = LINE_OFF_W'(1);

   fsm_state_t                     state;
   logic [ADDR_W-1:LINE_OFF_W]     base_line;
   logic [LINE_OFF_W-1:0]          k;
   logic [CNT_W-1:0]               wait_cnt;

   logic                           resp_valid_q;
   logic                           resp_last_q;
   logic                           wr_ack_q;
   logic [DATA_W-1:0]              resp_data_q;
   logic [ADDR_W-1:0]              resp_addr_q;

   logic                           ready;
   logic                           accept;
   logic                           ram_we;
   logic                           ram_re;
   logic                           ram_en;
   logic [ADDR_W-1:LINE_OFF_W]     rd_line;
   logic [LINE_OFF_W-1:0]          rd_off;
   logic [MEM_DEPTH_LOG2-1:0]      ram_idx;
   logic [DATA_W-1:0]              ram_rdata;

   // Ready also stays low while the registered response/ack pulse is still visible,
   // so a new request is never accepted in the same cycle as the previous one's last output.
   assign ready  = (state == ST_IDLE) && !resp_valid_q && !wr_ack_q;
   assign accept = bus.req_valid && ready;
   assign ram_we = accept && bus.req_write;

   // The RAM read for word k is issued on the edge that enters SEND, so the
   // word is in ram_rdata during SEND and registered onto the bus at its end.
   always_comb begin
      ram_re  = 1'b0;
      rd_line = base_line;
      rd_off  = k;
      case (state)
         ST_IDLE: begin
            if (accept && !bus.req_write && NO_WAIT) begin
               ram_re  = 1'b1;
               rd_line = bus.req_addr[ADDR_W-1:LINE_OFF_W];
               rd_off  = '0;
            end
         end
         ST_WAIT: begin
            ram_re = (wait_cnt == CNT_LAST);
         end
         ST_SEND: begin
            if (NO_WAIT && (k != LAST_OFF)) begin
               ram_re = 1'b1;
               rd_off = k + OFF_ONE;
            end
         end
         default: begin
            ram_re = 1'b0;
         end
      endcase
   end

   assign ram_en  = ram_we || ram_re;
   assign ram_idx = ram_we ? bus.req_addr[MEM_DEPTH_LOG2-1:0]
                           : MEM_DEPTH_LOG2'({rd_line, rd_off});

   mem_array #(
      .DATA_W         (DATA_W),
      .MEM_DEPTH_LOG2 (MEM_DEPTH_LOG2)
   ) u_mem (
      .clk   (clk_100),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_idx),
      .wdata (bus.req_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk_100 or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         base_line    <= '0;
         k            <= '0;
         wait_cnt     <= '0;
         resp_valid_q <= 1'b0;
         resp_last_q  <= 1'b0;
         wr_ack_q     <= 1'b0;
         resp_data_q  <= '0;
         resp_addr_q  <= '0;
      end else begin
         resp_valid_q <= (state == ST_SEND);
         resp_last_q  <= (state == ST_SEND) && (k == LAST_OFF);
         wr_ack_q     <= (state == ST_WACK);
         if (state == ST_SEND) begin
            resp_data_q <= ram_rdata;
            resp_addr_q <= {base_line, k};
         end
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (bus.req_write) begin
                     state <= ST_WACK;
                  end else begin
                     base_line <= bus.req_addr[ADDR_W-1:LINE_OFF_W];
                     k         <= '0;
                     wait_cnt  <= '0;
                     state     <= NO_WAIT ? ST_SEND : ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == CNT_LAST) begin
                  wait_cnt <= '0;
                  state    <= ST_SEND;
               end else begin
                  wait_cnt <= wait_cnt + CNT_ONE;
               end
            end
            ST_SEND: begin
               if (k == LAST_OFF) begin
                  state <= ST_IDLE;
               end else begin
                  k     <= k + OFF_ONE;
                  state <= NO_WAIT ? ST_SEND : ST_WAIT;
               end
            end
            ST_WACK: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_last  = resp_last_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_addr  = resp_addr_q;
   assign bus.wr_ack     = wr_ack_q;

endmodule
